instr_fetch_seq: RTL and testbench
==================================

INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 SHALL have parameter AW, default 32, meaning the byte address width.
REQ-003 SHALL have port clk_i, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port enable_i, input, 1 bit: when 1, new fetches are permitted.
REQ-006 SHALL have port req_o, output, 1 bit: instruction memory read request.
REQ-007 SHALL have port addr_o, output, AW bits: request byte address, with addr_o[2:0] always 0.
REQ-008 SHALL have port gnt_i, input, 1 bit: memory accepts the request this cycle.
REQ-009 SHALL have port rvalid_i, input, 1 bit: read data valid.
REQ-010 SHALL have port rdata_i, input, 64 bits: the instruction word.
REQ-011 SHALL have port issue_valid_o, output, 1 bit: an instruction is presented to the decoder.
REQ-012 SHALL have port issue_ready_i, input, 1 bit: the decoder/execute stage accepts it.
REQ-013 SHALL have port instr_o, output, 64 bits: the head instruction (op in [7:0], imm32 in [63:32]).
REQ-014 SHALL have port pc_o, output, AW bits: the address of instr_o.
REQ-015 SHALL have port redirect_i, input, 1 bit: branch/redirect strobe.
REQ-016 SHALL have port redirect_pc_i, input, AW bits: redirect target.
REQ-017 SHALL have port stall_cnt_o, output, 32 bits: issue starvation counter.

Function
REQ-018 SHALL hold the fetch PC; it advances by 8 on each granted request.
REQ-019 SHALL keep a 2-entry FIFO of {instr, pc}; issue_valid_o = FIFO not empty; instr_o/pc_o = FIFO head.
REQ-020 SHALL pop the FIFO head when issue_valid_o && issue_ready_i.
REQ-021 SHALL use FSM states IDLE (no request), REQ (req_o=1), WAIT (granted, awaiting rvalid_i).
REQ-022 IDLE->REQ when enable_i=1, no redirect, and FIFO occupancy + outstanding < 2; REQ->WAIT on gnt_i; WAIT->REQ on rvalid_i if the IDLE->REQ conditions hold, else WAIT->IDLE.
REQ-023 SHALL hold req_o=1 with addr_o stable until gnt_i; at most one request outstanding.
REQ-024 SHALL push {rdata_i, address of the request} into the FIFO on rvalid_i, unless that response is marked discard.
REQ-025 rvalid_i SHALL arrive at least 1 cycle after gnt_i; a rvalid_i in IDLE/REQ SHALL be ignored.
REQ-026 On redirect_i, the FIFO SHALL flush and PC SHALL become {redirect_pc_i[AW-1:3],3'b000}; the next request uses the new PC.
REQ-027 Redirect in WAIT, or in REQ on the cycle gnt_i=1, SHALL mark the outstanding response discard; redirect in REQ without gnt_i SHALL keep req_o/addr_o unchanged until grant, and that response SHALL be discarded.
REQ-028 Redirect coinciding with rvalid_i SHALL discard that data.
REQ-029 Redirect coinciding with an issue handshake SHALL treat the instruction as consumed, then flush.
REQ-030 Pop and push in the same cycle with FIFO full SHALL be legal; occupancy is unchanged.
REQ-031 enable_i=0 SHALL block only new requests; a pending request/response completes normally.
REQ-032 Latency: rvalid_i at cycle N with FIFO empty gives issue_valid_o=1 at N+1.

Reset
REQ-033 On rst_i=1 at a clock edge: PC=RESET_PC, FSM=IDLE, FIFO empty, discard flag cleared, req_o=0, issue_valid_o=0, stall_cnt_o=0.
REQ-034 rst_i mid-transaction SHALL abandon the outstanding request; a later rvalid_i for it SHALL be ignored (state IDLE).

Configuration
REQ-035 Macro FETCH_STALL_CNT_EN defined: stall_cnt_o increments, saturating at 32'hFFFF_FFFF, each cycle enable_i=1, issue_ready_i=1 and issue_valid_o=0; cleared by reset.
REQ-036 Macro FETCH_STALL_CNT_EN undefined: stall_cnt_o is constant 0 and no counter logic exists.

Verification
REQ-037 Reset, enable_i=1, gnt_i=1, rvalid_i one cycle after grant, rdata=64'h0000_0001_0203_0410 -> addr_o 0x0 then 0x8; instr_o=that word, pc_o=0x0.
REQ-038 issue_ready_i=0, continuous grants and data -> exactly 2 entries (pc 0x0, 0x8); req_o stays 0 afterwards, with no third request.
REQ-039 Redirect to 0x1004 while in WAIT -> the next rvalid_i data is dropped; the next addr_o is 0x1000; the FIFO is empty in the cycle after the redirect.
REQ-040 gnt_i held low 5 cycles -> req_o=1 and addr_o stable for all 5 cycles; one push after rvalid_i.
REQ-041 With FETCH_STALL_CNT_EN, ready=1 and memory idle for 10 cycles with FIFO empty -> stall_cnt_o=10; without the macro -> 0.
REQ-042 rst_i asserted in WAIT, rvalid_i next cycle -> FIFO stays empty, addr_o=RESET_PC on the next request.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: one-outstanding-request memory FSM feeding a 2-entry {instr, pc} FIFO.
// Optional issue-starvation counter is compiled in when FETCH_STALL_CNT_EN is defined.
module instr_fetch_seq #(
  parameter int unsigned     AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  output logic          req_o,
  output logic [AW-1:0] addr_o,
  input  logic          gnt_i,
  input  logic          rvalid_i,
  input  logic [63:0]   rdata_i,
  output logic          issue_valid_o,
  input  logic          issue_ready_i,
  output logic [63:0]   instr_o,
  output logic [AW-1:0] pc_o,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic [31:0]   stall_cnt_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic [AW-1:0] ResetPcAligned = {RESET_PC[AW-1:3], 3'b000};

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic          discard_q, discard_d;
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [63:0]   instr_q [2];
  logic [63:0]   instr_d [2];
  logic [AW-1:0] fpc_q [2];
  logic [AW-1:0] fpc_d [2];

  logic          push, pop, can_fetch;
  logic [AW-1:0] redirect_pc;
  logic          unused_redirect_lsb;

  assign redirect_pc         = {redirect_pc_i[AW-1:3], 3'b000};
  assign unused_redirect_lsb = ^redirect_pc_i[2:0];

  assign req_o         = (state_q == StReq);
  assign addr_o        = req_addr_q;
  assign issue_valid_o = (count_q != 2'd0);
  assign instr_o       = instr_q[rd_ptr_q];
  assign pc_o          = fpc_q[rd_ptr_q];

  // FIFO bookkeeping; a redirect flushes after any same-cycle pop.
  always_comb begin
    pop      = issue_valid_o && issue_ready_i;
    push     = (state_q == StWait) && rvalid_i && !discard_q && !redirect_i;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    instr_d  = instr_q;
    fpc_d    = fpc_q;
    if (push) begin
      instr_d[wr_ptr_q] = rdata_i;
      fpc_d[wr_ptr_q]   = req_addr_q;
    end
    if (redirect_i) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
    end
  end

  // Occupancy after this cycle's push/pop must leave room for the new request.
  assign can_fetch = enable_i && !redirect_i && (count_d < 2'd2);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;

    unique case (state_q)
      StIdle: begin
        discard_d = 1'b0;
        if (can_fetch) begin
          state_d    = StReq;
          req_addr_d = pc_q;
        end
      end
      StReq: begin
        discard_d = discard_q | redirect_i;
        if (gnt_i) begin
          state_d = StWait;
          if (!redirect_i && !discard_q) pc_d = pc_q + AW'(8);
        end
      end
      StWait: begin
        if (rvalid_i) begin
          discard_d = 1'b0;
          if (can_fetch) begin
            state_d    = StReq;
            req_addr_d = pc_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          discard_d = discard_q | redirect_i;
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect_i) pc_d = redirect_pc;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pc_q       <= ResetPcAligned;
      req_addr_q <= ResetPcAligned;
      discard_q  <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    instr_q <= instr_d;
    fpc_q   <= fpc_d;
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (enable_i && issue_ready_i && !issue_valid_o && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= 32'd0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed self-checking bench for instr_fetch_seq (AW=32, RESET_PC=0).
module tb_instr_fetch_seq;

  logic        clk_i = 1'b0;
  logic        rst_i, enable_i, gnt_i, rvalid_i, issue_ready_i, redirect_i;
  logic [63:0] rdata_i;
  logic [31:0] redirect_pc_i;
  logic        req_o, issue_valid_o;
  logic [31:0] addr_o, pc_o, stall_cnt_o;
  logic [63:0] instr_o;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] W0 = 64'h0000_0001_0203_0410;
  localparam logic [63:0] W1 = 64'hAAAA_0002_0000_0021;
  localparam logic [63:0] W2 = 64'hBBBB_0003_0000_0032;
  localparam logic [63:0] W3 = 64'hDEAD_BEEF_0000_0043;
  localparam logic [63:0] W4 = 64'h1234_5678_0000_0054;
  localparam logic [63:0] W5 = 64'hCAFE_F00D_0000_0065;

`ifdef FETCH_STALL_CNT_EN
  localparam logic [31:0] StallExp = 32'd10;
`else
  localparam logic [31:0] StallExp = 32'd0;
`endif

  always #5 clk_i = ~clk_i;

  instr_fetch_seq #(
    .AW       (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .req_o         (req_o),
    .addr_o        (addr_o),
    .gnt_i         (gnt_i),
    .rvalid_i      (rvalid_i),
    .rdata_i       (rdata_i),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_cnt_o   (stall_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    issue_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    cycle();
    cycle();
    check("rst_req", req_o, 0);
    check("rst_valid", issue_valid_o, 0);
    check("rst_stall", stall_cnt_o, 0);

    // Basic fetch: request at 0x0, then 0x8 after the response.
    rst_i = 1'b0; enable_i = 1'b1; gnt_i = 1'b1;
    cycle();
    check("req0", req_o, 1);
    check("addr0", addr_o, 32'h0);
    cycle();
    check("wait0_req", req_o, 0);
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = W0;
    cycle();
    check("lat_valid", issue_valid_o, 1);
    check("instr0", instr_o, W0);
    check("pc0", pc_o, 32'h0);
    check("addr8", addr_o, 32'h8);

    // Decoder stalled: FIFO fills to two entries and fetching stops.
    rvalid_i = 1'b0; gnt_i = 1'b1;
    cycle();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = W1;
    cycle();
    rvalid_i = 1'b0;
    check("full_req", req_o, 0);
    check("full_head_pc", pc_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("full_no_req", req_o, 0);
    end
    issue_ready_i = 1'b1;
    cycle();
    issue_ready_i = 1'b0;
    check("pop_pc", pc_o, 32'h8);
    check("pop_instr", instr_o, W1);
    check("refetch_req", req_o, 1);
    check("refetch_addr", addr_o, 32'h10);

    // Grant withheld for five cycles: request and address hold.
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_req", req_o, 1);
      check("hold_addr", addr_o, 32'h10);
    end
    gnt_i = 1'b1;
    cycle();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = W2;
    cycle();
    rvalid_i = 1'b0;
    check("two_head_pc", pc_o, 32'h8);
    check("two_req", req_o, 0);
    issue_ready_i = 1'b1;
    cycle();
    issue_ready_i = 1'b0;
    check("pop2_pc", pc_o, 32'h10);
    check("pop2_instr", instr_o, W2);
    check("req18_addr", addr_o, 32'h18);

    // Redirect while waiting: FIFO flushed, in-flight data dropped.
    gnt_i = 1'b1;
    cycle();
    gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h1004;
    cycle();
    redirect_i = 1'b0;
    check("redir_flush", issue_valid_o, 0);
    rvalid_i = 1'b1; rdata_i = W3;
    cycle();
    rvalid_i = 1'b0;
    check("redir_drop", issue_valid_o, 0);
    check("redir_req", req_o, 1);
    check("redir_addr", addr_o, 32'h1000);
    gnt_i = 1'b1;
    cycle();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = W4;
    cycle();
    rvalid_i = 1'b0;
    check("redir_instr", instr_o, W4);
    check("redir_pc", pc_o, 32'h1000);
    check("next_addr", addr_o, 32'h1008);

    // Reset in WAIT: late response ignored, refetch from reset PC.
    gnt_i = 1'b1;
    cycle();
    gnt_i = 1'b0; rst_i = 1'b1;
    cycle();
    rst_i = 1'b0; enable_i = 1'b0; rvalid_i = 1'b1; rdata_i = W5;
    cycle();
    rvalid_i = 1'b0;
    check("rst_drop_valid", issue_valid_o, 0);
    check("rst_drop_req", req_o, 0);
    enable_i = 1'b1;
    cycle();
    check("rst_refetch_req", req_o, 1);
    check("rst_refetch_addr", addr_o, 32'h0);

    // Starvation counter over ten cycles with idle memory.
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    check("stall_clr", stall_cnt_o, 0);
    issue_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    check("stall_cnt", stall_cnt_o, StallExp);
    issue_ready_i = 1'b0;

    // Redirect in REQ without grant: request unchanged, response discarded.
    check("preredir_addr", addr_o, 32'h0);
    redirect_i = 1'b1; redirect_pc_i = 32'h2000;
    cycle();
    redirect_i = 1'b0;
    check("rq_redir_req", req_o, 1);
    check("rq_redir_addr", addr_o, 32'h0);
    gnt_i = 1'b1;
    cycle();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = W5;
    cycle();
    rvalid_i = 1'b0;
    check("rq_redir_drop", issue_valid_o, 0);
    check("rq_redir_new", addr_o, 32'h2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
